// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - IF stage: fetch PC, single-outstanding imem handshake, IF/ID register
// Squashes wrong-path words after a redirect and parks a returning word in a skid buffer during stalls.
module instruction_fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter logic [31:0] NOP_ENC  = 32'hD503201F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        BrTaken,
  input  logic [63:0] realBranchingAddr,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [63:0] PC,
  output logic        InstrValid
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD} stateT;

  stateT       state, stateNext;
  logic [63:0] fetchPc, reqPc, skidPc;
  logic [31:0] skidInstr;
  logic        discard;
  logic        redirect, accept;
  logic        loadWord, loadSkid, toSkid, setDiscard, clrDiscard;

  assign redirect  = BrTaken & ~Stall;
  assign accept    = imem_req & imem_ready;
  assign imem_addr = fetchPc;

  always_comb begin
    stateNext  = state;
    imem_req   = 1'b0;
    loadWord   = 1'b0;
    loadSkid   = 1'b0;
    toSkid     = 1'b0;
    setDiscard = 1'b0;
    clrDiscard = 1'b0;
    case (state)
      FETCH: begin
        imem_req = ~Stall & ~BrTaken;
        if (accept) stateNext = WAIT;
      end
      WAIT: begin
        if (!imem_rvalid) begin
          if (redirect) setDiscard = 1'b1;
        end else if (discard) begin
          clrDiscard = 1'b1;
          stateNext  = FETCH;
        end else if (Stall) begin
          toSkid    = 1'b1;
          stateNext = HOLD;
        end else if (redirect) begin
          stateNext = FETCH;
        end else begin
          // Back-to-back: next request goes out in the same cycle the word lands.
          loadWord  = 1'b1;
          imem_req  = 1'b1;
          stateNext = accept ? WAIT : FETCH;
        end
      end
      HOLD: begin
        if (!Stall) begin
          loadSkid  = 1'b1;
          stateNext = FETCH;
        end
      end
      default: stateNext = FETCH;
    endcase
    if (reset) imem_req = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      fetchPc     <= RESET_PC;
      reqPc       <= 64'd0;
      discard     <= 1'b0;
      skidInstr   <= 32'd0;
      skidPc      <= 64'd0;
      instruction <= NOP_ENC;
      PC          <= 64'd0;
      InstrValid  <= 1'b0;
    end else begin
      state <= stateNext;
      if (redirect)    fetchPc <= realBranchingAddr;
      else if (accept) fetchPc <= fetchPc + 64'd4;
      if (accept) reqPc <= fetchPc;
      if (setDiscard)      discard <= 1'b1;
      else if (clrDiscard) discard <= 1'b0;
      if (toSkid) begin
        skidInstr <= imem_rdata;
        skidPc    <= reqPc;
      end
      // A redirect always wins over loading a word, so the wrong path never reaches decode.
      if (redirect) begin
        instruction <= NOP_ENC;
        PC          <= 64'd0;
        InstrValid  <= 1'b0;
      end else if (loadWord) begin
        instruction <= imem_rdata;
        PC          <= reqPc;
        InstrValid  <= 1'b1;
      end else if (loadSkid) begin
        instruction <= skidInstr;
        PC          <= skidPc;
        InstrValid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - scoreboard bench for instruction_fetch_stage
// Memory model answers after a programmable latency; monitors pop expected requests and IF/ID words.
module tb_instruction_fetch_stage;

  localparam logic [31:0] NOP    = 32'hD503201F;
  localparam logic [96:0] BUBBLE = {1'b0, NOP, 64'd0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Stall = 1'b0;
  logic        BrTaken = 1'b0;
  logic [63:0] realBranchingAddr = 64'd0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instruction;
  logic [63:0] PC;
  logic        InstrValid;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  logic [63:0] expAddr[$];
  logic [95:0] expIfid[$];

  logic        accS, pend;
  logic [63:0] accA, pAddr;
  int          cnt;
  logic [96:0] prevIf, curIf;

  always #5 clk = ~clk;

  instruction_fetch_stage #(.RESET_PC(64'd0), .NOP_ENC(NOP)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .BrTaken(BrTaken),
    .realBranchingAddr(realBranchingAddr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instruction), .PC(PC), .InstrValid(InstrValid)
  );

  function automatic logic [31:0] memWord(input logic [63:0] a);
    return a[31:0] ^ 32'hA5000000;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic pushIf(input logic [63:0] pc);
    expIfid.push_back({memWord(pc), pc});
  endtask

  task automatic chkBubble(input string name);
    check(name, 128'({InstrValid, instruction, PC}), 128'(BUBBLE));
  endtask

  task automatic chkReq(input string name, input logic req, input logic [63:0] addr);
    check(name, 128'({imem_req, imem_addr}), 128'({req, addr}));
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Memory model and request scoreboard
  initial begin
    pend = 1'b0; pAddr = 64'd0; cnt = 0;
    forever begin
      @(negedge clk);
      accS = !reset && imem_req && imem_ready;
      accA = imem_addr;
      if (accS) begin
        if (expAddr.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_addr unexpected request actual=%h required=none", accA);
        end else begin
          check("req_addr", 128'(accA), 128'(expAddr.pop_front()));
        end
        check("one_outstanding", 128'(pend), 128'(1'b0));
      end
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (accS) begin
        pend = 1'b1; pAddr = accA; cnt = lat;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 1'b0;
          imem_rvalid = 1'b1;
          imem_rdata = memWord(pAddr);
        end
      end
    end
  end

  // IF/ID monitor: every newly presented valid instruction pops the scoreboard
  initial begin
    prevIf = '0;
    forever begin
      @(negedge clk);
      curIf = {InstrValid, instruction, PC};
      if (!reset && curIf != prevIf && InstrValid) begin
        if (expIfid.size() == 0) begin
          checks++; errors++;
          $display("FAIL ifid unexpected word actual=%h required=none", curIf);
        end else begin
          check("ifid", 128'(curIf), 128'({1'b1, expIfid.pop_front()}));
        end
      end
      prevIf = curIf;
    end
  end

  initial begin
    repeat (2) step();
    chkBubble("rst_ifid");
    chkReq("rst_req", 1'b0, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) expAddr.push_back(64'(4 * i));
    for (int i = 0; i < 4; i++) pushIf(64'(4 * i));
    repeat (3) step();
    Stall = 1'b1;
    step();
    check("stall_hold", 128'({InstrValid, PC}), 128'({1'b1, 64'd4}));
    step();
    Stall = 1'b0;
    check("stall_release_hold", 128'({InstrValid, PC}), 128'({1'b1, 64'd4}));
    repeat (3) step();
    BrTaken = 1'b1; realBranchingAddr = 64'h100;
    expAddr.push_back(64'h100); expAddr.push_back(64'h104); expAddr.push_back(64'h108);
    pushIf(64'h100); pushIf(64'h104);
    step();
    BrTaken = 1'b0; #1;
    chkBubble("br_bubble");
    chkReq("br_target_req", 1'b1, 64'h100);
    repeat (2) step();
    lat = 3;
    step();
    BrTaken = 1'b1; realBranchingAddr = 64'h200;
    expAddr.push_back(64'h200); expAddr.push_back(64'h204);
    pushIf(64'h200);
    step();
    BrTaken = 1'b0; #1;
    chkBubble("wait_br_bubble");
    chkReq("wait_br_noreq", 1'b0, 64'h200);
    step();
    chkReq("stale_noreq", 1'b0, 64'h200);
    step();
    chkBubble("stale_dropped");
    chkReq("discard_then_fetch", 1'b1, 64'h200);
    repeat (4) step();
    lat = 1;
    step();
    Stall = 1'b1; BrTaken = 1'b1; realBranchingAddr = 64'h300;
    expAddr.push_back(64'h208);
    pushIf(64'h204);
    step();
    Stall = 1'b0; BrTaken = 1'b0; #1;
    chkReq("stall_br_ignored", 1'b1, 64'h208);
    step();
    BrTaken = 1'b1; realBranchingAddr = 64'h300;
    expAddr.push_back(64'h300); expAddr.push_back(64'h304);
    pushIf(64'h300); pushIf(64'h304);
    step();
    BrTaken = 1'b0; #1;
    chkBubble("br2_bubble");
    chkReq("br2_req", 1'b1, 64'h300);
    repeat (2) step();
    lat = 3;
    expAddr.push_back(64'h308);
    step();
    #4; reset = 1'b1; #1;
    chkBubble("async_rst_ifid");
    chkReq("async_rst_req", 1'b0, 64'd0);
    step();
    reset = 1'b0; imem_ready = 1'b0; lat = 1; #1;
    chkReq("post_rst_req", 1'b1, 64'd0);
    step();
    step();
    chkBubble("late_rvalid_ignored");
    expAddr.push_back(64'd0); expAddr.push_back(64'd4);
    pushIf(64'd0); pushIf(64'd4);
    imem_ready = 1'b1;
    repeat (2) step();
    imem_ready = 1'b0;
    repeat (3) step();
    check("ifid_queue_drained", 128'(expIfid.size()), 128'(0));
    check("addr_queue_drained", 128'(expAddr.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
